// File: rtl/mdu_pkg.sv
// Shared MDU op encodings, controller state and decode helpers.
// Optional MADD/MADDU/MSUB/MSUBU decode is enabled by MDU_MADD_EN.
package mdu_pkg;

   localparam int COUNT_W = 4;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8,
      MDU_MADD  = 4'd9,
      MDU_MADDU = 4'd10,
      MDU_MSUB  = 4'd11,
      MDU_MSUBU = 4'd12
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   // Ops that occupy the unit for a multi-cycle run.
   function automatic logic is_start_op(input logic [3:0] op);
      logic s;
      s = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
      s = s || (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
      return s;
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   // Anything touching HI/LO; illegal while a run is in progress.
   function automatic logic is_hilo_op(input logic [3:0] op);
      return is_start_op(op) || (op == MDU_MFHI) || (op == MDU_MFLO) ||
             (op == MDU_MTHI) || (op == MDU_MTLO);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result for MULT/DIV (and MADD/MSUB under MDU_MADD_EN).
// Zero latency; divide by zero passes current hi/lo through unchanged.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic [3:0]  op,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] hi_next,
   output logic [31:0] lo_next
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        sdiv;
   logic        div_zero;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic [31:0] q_u;
   logic [31:0] r_u;
   logic [31:0] quot;
   logic [31:0] rem;

   always_comb begin
      // Low 64 bits of a sign-extended unsigned multiply equal the signed product.
      prod_s   = {{32{in1[31]}}, in1} * {{32{in2[31]}}, in2};
      prod_u   = {32'd0, in1} * {32'd0, in2};
      sdiv     = (op == MDU_DIV);
      div_zero = (in2 == 32'd0);
      mag1     = (sdiv && in1[31]) ? -in1 : in1;
      mag2     = (sdiv && in2[31]) ? -in2 : in2;
      q_u      = div_zero ? 32'd0 : mag1 / mag2;
      r_u      = div_zero ? 32'd0 : mag1 % mag2;
      quot     = (sdiv && (in1[31] ^ in2[31])) ? -q_u : q_u;
      rem      = (sdiv && in1[31]) ? -r_u : r_u;

      hi_next = hi;
      lo_next = lo;
      case (op)
         MDU_MULT:  {hi_next, lo_next} = prod_s;
         MDU_MULTU: {hi_next, lo_next} = prod_u;
         MDU_DIV, MDU_DIVU: begin
            if (!div_zero) begin
               hi_next = rem;
               lo_next = quot;
            end
         end
`ifdef MDU_MADD_EN
         MDU_MADD:  {hi_next, lo_next} = {hi, lo} + prod_s;
         MDU_MADDU: {hi_next, lo_next} = {hi, lo} + prod_u;
         MDU_MSUB:  {hi_next, lo_next} = {hi, lo} - prod_s;
         MDU_MSUBU: {hi_next, lo_next} = {hi, lo} - prod_u;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller owning HI/LO; MULT_CYCLES/DIV_CYCLES busy, MT* 1 edge.
// Stalls D while busy or starting; a started run ignores flush. MDU_MADD_EN adds MADD/MSUB.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic [3:0]  op,
   input  logic        flush,
   input  logic        d_is_mdu,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data
);

   mdu_state_e         state;
   mdu_state_e         state_nxt;
   logic [COUNT_W-1:0] cnt;
   logic [31:0]        hi_buf;
   logic [31:0]        lo_buf;
   logic [31:0]        hi_calc;
   logic [31:0]        lo_calc;
   logic               start;
   logic               last;

   assign start = (state == ST_IDLE) && is_start_op(op) && !flush;
   assign last  = (state == ST_RUN) && (cnt == COUNT_W'(1));

   mdu_calc u_calc (
      .in1     (in1),
      .in2     (in2),
      .op      (op),
      .hi      (hi),
      .lo      (lo),
      .hi_next (hi_calc),
      .lo_next (lo_calc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN:  if (last)  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state == ST_RUN);
      stall   = d_is_mdu && (busy || start);
      rd_data = 32'd0;
      if (op == MDU_MFHI)      rd_data = hi;
      else if (op == MDU_MFLO) rd_data = lo;
   end

   // Result is captured at start; HI/LO only change architecturally on the final edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         hi_buf <= 32'd0;
         lo_buf <= 32'd0;
         hi     <= 32'd0;
         lo     <= 32'd0;
      end else begin
         if (start) begin
            cnt    <= is_div_op(op) ? COUNT_W'(DIV_CYCLES) : COUNT_W'(MULT_CYCLES);
            hi_buf <= hi_calc;
            lo_buf <= lo_calc;
         end else if (state == ST_RUN) begin
            cnt <= cnt - COUNT_W'(1);
         end

         if (last) begin
            hi <= hi_buf;
            lo <= lo_buf;
         end else if ((state == ST_IDLE) && !flush) begin
            if (op == MDU_MTHI) hi <= in1;
            if (op == MDU_MTLO) lo <= in1;
         end
      end
   end

   a_no_hilo_op_in_run: assert property (@(posedge clk) disable iff (!reset)
      (state == ST_RUN) |-> !is_hilo_op(op));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized plus directed bench for mdu_ctrl against a 64-bit arithmetic reference model.
module tb_mdu_ctrl;
   import mdu_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [3:0]  op;
   logic        flush;
   logic        d_is_mdu;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rd_data;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_hi   = 32'd0;
   logic [31:0] exp_lo   = 32'd0;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk      (clk),
      .reset    (reset),
      .in1      (in1),
      .in2      (in2),
      .op       (op),
      .flush    (flush),
      .d_is_mdu (d_is_mdu),
      .busy     (busy),
      .stall    (stall),
      .hi       (hi),
      .lo       (lo),
      .rd_data  (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Architectural effect of one completed op on {hi,lo}.
   task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      longint          res;
      sa  = $signed(a);
      sb  = $signed(b);
      ua  = a;
      ub  = b;
      res = {exp_hi, exp_lo};
      case (o)
         MDU_MULT:  res = sa * sb;
         MDU_MULTU: res = longint'(ua * ub);
         MDU_DIV:   if (b != 0) res = {32'(sa % sb), 32'(sa / sb)};
         MDU_DIVU:  if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
         MDU_MTHI:  res = {a, exp_lo};
         MDU_MTLO:  res = {exp_hi, a};
`ifdef MDU_MADD_EN
         MDU_MADD:  res = res + sa * sb;
         MDU_MADDU: res = res + longint'(ua * ub);
         MDU_MSUB:  res = res - sa * sb;
         MDU_MSUBU: res = res - longint'(ua * ub);
`endif
         default: ;
      endcase
      exp_hi = res[63:32];
      exp_lo = res[31:0];
   endtask

   // Issue a multi-cycle op from IDLE with D-stage MDU traffic held; optional flush pulse on busy cycle flush_at.
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int n_exp, input int flush_at);
      int n;
      op = o; in1 = a; in2 = b; d_is_mdu = 1'b1; flush = 1'b0;
      #1;
      chk("stall_start", stall, 1);
      @(posedge clk); #1;
      op = MDU_NONE;
      model(o, a, b);
      n = 0;
      while (busy && n < 40) begin
         flush = (n == flush_at);
         chk("stall_busy", stall, 1);
         n++;
         @(posedge clk); #1;
      end
      flush = 1'b0;
      chk("busy_cycles", n, n_exp);
      chk("stall_after", stall, 0);
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
      op = MDU_MFLO; #1;
      chk("mflo", rd_data, exp_lo);
      op = MDU_MFHI; #1;
      chk("mfhi", rd_data, exp_hi);
      op = MDU_NONE; d_is_mdu = 1'b0;
   endtask

   task automatic move_to(input logic [3:0] o, input logic [31:0] v);
      op = o; in1 = v; flush = 1'b0;
      @(posedge clk); #1;
      model(o, v, 32'd0);
      op = (o == MDU_MTHI) ? MDU_MFHI : MDU_MFLO;
      #1;
      chk("mt_readback", rd_data, (o == MDU_MTHI) ? exp_hi : exp_lo);
      op = MDU_NONE;
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($urandom_range(0, 16)) - 32'd8;
         2:       return $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
         default: return 32'd0;
      endcase
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] o;
      reset = 1'b0; in1 = 32'd0; in2 = 32'd0; op = MDU_MFHI; flush = 1'b0; d_is_mdu = 1'b1;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_rd", rd_data, 0);
      reset = 1'b1; op = MDU_NONE; d_is_mdu = 1'b0;
      @(posedge clk); #1;

      run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, MC, -1);
      chk("mult_hi_k", hi, 32'hFFFF_FFFF);
      chk("mult_lo_k", lo, 32'hFFFF_FFFA);
      run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, MC, -1);
      chk("multu_hi_k", hi, 32'h0000_0002);
      chk("multu_lo_k", lo, 32'hFFFF_FFFA);
      run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, DC, -1);
      chk("div_lo_k", lo, 32'hFFFF_FFFD);
      chk("div_hi_k", hi, 32'hFFFF_FFFF);
      run_op(MDU_DIVU, 32'd7, 32'd0, DC, -1);
      chk("div0_hi_k", hi, 32'hFFFF_FFFF);
      chk("div0_lo_k", lo, 32'hFFFF_FFFD);

      // Start cancelled by flush in the same cycle.
      op = MDU_MULT; in1 = 32'd9; in2 = 32'd9; flush = 1'b1; d_is_mdu = 1'b1;
      #1;
      chk("flush_start_stall", stall, 0);
      @(posedge clk); #1;
      chk("flush_start_busy", busy, 0);
      chk("flush_start_hi", hi, exp_hi);
      chk("flush_start_lo", lo, exp_lo);
      op = MDU_NONE; flush = 1'b0; d_is_mdu = 1'b0;

      run_op(MDU_MULT, 32'd1000, 32'hFFFF_FF00, MC, 2);

      move_to(MDU_MTHI, 32'h1234_5678);
      chk("mthi_k", hi, 32'h1234_5678);
      move_to(MDU_MTLO, 32'hCAFE_F00D);

      // Unknown/disabled op code: no start, no stall, no state change.
`ifndef MDU_MADD_EN
      op = MDU_MADD; in1 = 32'd2; in2 = 32'd3; d_is_mdu = 1'b1;
      #1;
      chk("madd_off_stall", stall, 0);
      @(posedge clk); #1;
      chk("madd_off_busy", busy, 0);
      chk("madd_off_lo", lo, exp_lo);
      op = MDU_NONE; d_is_mdu = 1'b0;
`else
      move_to(MDU_MTHI, 32'd0);
      move_to(MDU_MTLO, 32'd1);
      run_op(MDU_MADD, 32'd2, 32'd3, MC, -1);
      chk("madd_lo_k", lo, 32'd7);
      run_op(MDU_MSUB, 32'd4, 32'd5, MC, -1);
      run_op(MDU_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, -1);
      run_op(MDU_MSUBU, 32'h8000_0000, 32'd3, MC, -1);
`endif

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 5))
            0:       o = MDU_MULT;
            1:       o = MDU_MULTU;
            2:       o = MDU_DIV;
            3:       o = MDU_DIVU;
            4:       o = MDU_MTHI;
            default: o = MDU_MTLO;
         endcase
         if (o == MDU_MTHI || o == MDU_MTLO) move_to(o, rnd_opnd());
         else run_op(o, rnd_opnd(), rnd_opnd(), is_div_op(o) ? DC : MC,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);
      end

      // Reset in the third busy cycle of a DIV aborts with no commit.
      run_op(MDU_MULT, 32'd5, 32'd6, MC, -1);
      op = MDU_DIV; in1 = 32'd100; in2 = 32'd7;
      @(posedge clk); #1;
      op = MDU_NONE;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_reset_busy", busy, 1);
      reset = 1'b0;
      #1;
      chk("mid_reset_busy", busy, 0);
      chk("mid_reset_hi", hi, 0);
      chk("mid_reset_lo", lo, 0);
      #1 reset = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("post_reset_busy", busy, 0);
      chk("post_reset_hi", hi, 0);
      chk("post_reset_lo", lo, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
